// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer: op codes, FSM states,
// default geometry and the per-word ALU op mapping.
package alu_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int WORDS_DEF = 4;
    localparam int LW_DEF    = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_SBC  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A multi-word ADD is a plain add on word 0 and add-with-carry above it.
    function automatic logic [2:0] alu_op_for(input logic [2:0] op, input int unsigned idx);
        if (op == OP_ADD) begin
            return (idx == 0) ? OP_ADD : OP_ADC;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command, result and ALU-side signals of the sequencer.
// ALU_SEQ_FLAGS_EN adds the res_zero / res_ovf result flags.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4,
    parameter int LW    = 3
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_op;
    logic [LW-1:0]          cmd_len;
    logic [WIDTH*WORDS-1:0] cmd_a;
    logic [WIDTH*WORDS-1:0] cmd_b;
    logic                   cmd_ci;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH*WORDS-1:0] res_data;
    logic                   res_co;
    logic [2:0]             alu_op;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic                   alu_ci;
    logic [WIDTH-1:0]       alu_result;
    logic                   alu_co;
`ifdef ALU_SEQ_FLAGS_EN
    logic                   res_zero;
    logic                   res_ovf;
`endif

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_ci, res_ready, alu_result, alu_co,
        output cmd_ready, res_valid, res_data, res_co, alu_op, alu_a, alu_b, alu_ci
`ifdef ALU_SEQ_FLAGS_EN
        , output res_zero, res_ovf
`endif
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_ci, res_ready, alu_result, alu_co,
        input  cmd_ready, res_valid, res_data, res_co, alu_op, alu_a, alu_b, alu_ci
`ifdef ALU_SEQ_FLAGS_EN
        , input res_zero, res_ovf
`endif
    );

endinterface

// File: rtl/alu_seq_fsm.sv
// Sequencer control: IDLE/RUN/DONE state, word index and clamped command length.
module alu_seq_fsm
    import alu_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid_i,
    input  logic [LW-1:0] cmd_len_i,
    input  logic          res_ready_i,
    output state_t        state_o,
    output logic [LW-1:0] idx_o,
    output logic          last_o,
    output logic          cmd_ready_o,
    output logic          res_valid_o
);
    state_t        state_q;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_d;
    logic          cmd_ready_q;
    logic          res_valid_q;

    // Zero-length and oversize commands both mean "all WORDS words".
    assign len_d = (cmd_len_i == '0 || cmd_len_i > LW'(WORDS)) ? LW'(WORDS) : cmd_len_i;
    assign last_o = (idx_q == len_q - LW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        state_q     <= S_RUN;
                        idx_q       <= '0;
                        len_q       <= len_d;
                        cmd_ready_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    idx_q <= idx_q + LW'(1);
                    if (last_o) begin
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        state_q     <= S_IDLE;
                        idx_q       <= '0;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o     = state_q;
    assign idx_o       = idx_q;
    assign cmd_ready_o = cmd_ready_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-word ALU sequencer top: operand/result registers and carry chaining.
// ALU_SEQ_FLAGS_EN adds registered res_zero / res_ovf result flags.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                 state;
    logic [LW-1:0]          idx;
    logic                   last;
    logic                   cmd_ready;
    logic                   res_valid;
    logic [2:0]             op_q;
    logic [WIDTH*WORDS-1:0] a_q;
    logic [WIDTH*WORDS-1:0] b_q;
    logic                   ci_q;
    logic                   carry_q;
    logic                   res_co_q;
    logic [WIDTH-1:0]       a_word     [WORDS];
    logic [WIDTH-1:0]       b_word     [WORDS];
    logic [WIDTH-1:0]       res_word_q [WORDS];
    logic [WIDTH-1:0]       res_word_d [WORDS];
    logic [IW-1:0]          idx_w;
    logic                   in_run;
    logic                   accept;
    logic                   is_arith;
    logic                   first_word;

    alu_seq_fsm #(.WORDS(WORDS), .LW(LW)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (bus.cmd_valid),
        .cmd_len_i   (bus.cmd_len),
        .res_ready_i (bus.res_ready),
        .state_o     (state),
        .idx_o       (idx),
        .last_o      (last),
        .cmd_ready_o (cmd_ready),
        .res_valid_o (res_valid)
    );

    assign idx_w      = idx[IW-1:0];
    assign in_run     = (state == S_RUN);
    assign accept     = bus.cmd_valid && cmd_ready;
    assign first_word = (idx == '0);
    assign is_arith   = (op_q == OP_ADD) || (op_q == OP_ADC) || (op_q == OP_SBC);

    // Result words start cleared on accept so words beyond len read as zero.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign a_word[gi]     = a_q[gi*WIDTH +: WIDTH];
        assign b_word[gi]     = b_q[gi*WIDTH +: WIDTH];
        assign res_word_d[gi] = (in_run && idx_w == IW'(gi)) ? bus.alu_result : res_word_q[gi];
        always_ff @(posedge clk) begin
            if (rst || accept) begin
                res_word_q[gi] <= '0;
            end else begin
                res_word_q[gi] <= res_word_d[gi];
            end
        end
        assign bus.res_data[gi*WIDTH +: WIDTH] = res_word_q[gi];
    end

    assign bus.alu_a  = in_run ? a_word[idx_w] : '0;
    assign bus.alu_b  = in_run ? b_word[idx_w] : '0;
    assign bus.alu_op = in_run ? alu_op_for(op_q, 32'(idx)) : OP_ADD;

    always_comb begin
        bus.alu_ci = 1'b0;
        if (in_run) begin
            if (first_word) begin
                bus.alu_ci = (op_q == OP_ADC || op_q == OP_SBC) ? ci_q : 1'b0;
            end else begin
                bus.alu_ci = is_arith & carry_q;
            end
        end
    end

    // alu_co is meaningless for logic ops, so it is masked before entering the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            ci_q     <= 1'b0;
            carry_q  <= 1'b0;
            res_co_q <= 1'b0;
        end else if (accept) begin
            op_q     <= bus.cmd_op;
            a_q      <= bus.cmd_a;
            b_q      <= bus.cmd_b;
            ci_q     <= bus.cmd_ci;
            carry_q  <= 1'b0;
            res_co_q <= 1'b0;
        end else if (in_run) begin
            carry_q <= is_arith & bus.alu_co;
            if (last) begin
                res_co_q <= is_arith & bus.alu_co;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_co    = res_co_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH*WORDS-1:0] res_flat_d;
    logic                   zero_q;
    logic                   ovf_q;
    logic                   a_sgn;
    logic                   b_sgn;
    logic                   r_sgn;
    logic                   ovf_d;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_flat
        assign res_flat_d[gi*WIDTH +: WIDTH] = res_word_d[gi];
    end

    assign a_sgn = a_word[idx_w][WIDTH-1];
    assign b_sgn = b_word[idx_w][WIDTH-1];
    assign r_sgn = bus.alu_result[WIDTH-1];
    // Subtraction overflows when operand signs differ; addition when they match.
    assign ovf_d = is_arith && (r_sgn != a_sgn) &&
                   ((op_q == OP_SBC) ? (a_sgn != b_sgn) : (a_sgn == b_sgn));

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_run && last) begin
            zero_q <= (res_flat_d == '0);
            ovf_q  <= ovf_d;
        end
    end

    assign bus.res_zero = zero_q;
    assign bus.res_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed, table-driven bench for alu_seq_ctrl with a behavioural 8-bit ALU.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.WIDTH(8), .WORDS(4), .LW(3)) bus ();

    alu_seq_ctrl #(.WIDTH(8), .WORDS(4), .LW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU; alu_co is deliberately 1 for ops whose carry is undefined.
    logic [8:0] alu_s;
    always_comb begin
        alu_s          = '0;
        bus.alu_result = '0;
        bus.alu_co     = 1'b1;
        case (bus.alu_op)
            3'd0: begin alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_result = alu_s[7:0]; bus.alu_co = alu_s[8]; end
            3'd1: begin alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_ci}; bus.alu_result = alu_s[7:0]; bus.alu_co = alu_s[8]; end
            3'd2: begin alu_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_ci}; bus.alu_result = alu_s[7:0]; bus.alu_co = alu_s[8]; end
            3'd3: bus.alu_result = bus.alu_a & bus.alu_b;
            3'd4: bus.alu_result = bus.alu_a | bus.alu_b;
            3'd5: bus.alu_result = bus.alu_a ^ bus.alu_b;
            3'd6: bus.alu_result = ~bus.alu_a;
            default: bus.alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  len;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] exp_data;
        logic        exp_co;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_op    = v.op;
        bus.cmd_len   = v.len;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.cmd_ci    = v.ci;
        bus.cmd_valid = 1'b1;
    endtask

    // Starts and ends at a negedge; n counts cycles from the accept cycle.
    task automatic run_vec(input int id, input vec_t v);
        int         le;
        int         n;
        bit         got;
        logic [11:0] ops_act;
        logic [11:0] ops_exp;
        le = (v.len == 3'd0 || v.len > 3'd4) ? 4 : int'(v.len);
        ops_act = '0;
        ops_exp = '0;
        for (int k = 0; k < le; k++) begin
            ops_exp[3*k +: 3] = (v.op == 3'd0 && k != 0) ? 3'd1 : v.op;
        end
        drive_cmd(v);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge clk);
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            bus.cmd_valid = 1'b0;
            if (bus.res_valid) got = 1;
            else if (n <= 4) ops_act[3*(n-1) +: 3] = bus.alu_op;
        end
        check("res_valid_timeout", got, 1);
        check("latency", n, le + 1);
        check("res_data", bus.res_data, v.exp_data);
        check("res_co", bus.res_co, v.exp_co);
        check("alu_op_seq", ops_act, ops_exp);
`ifdef ALU_SEQ_FLAGS_EN
        check("res_zero", bus.res_zero, (v.exp_data == 32'd0));
`endif
        $display("txn %0d op=%0d len=%0d a=%h b=%h ci=%b -> res=%h co=%b lat=%0d",
                 id, v.op, v.len, v.a, v.b, v.ci, bus.res_data, bus.res_co, n);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("post_res_valid", bus.res_valid, 0);
        check("post_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        bit   seen;
        int   n;
        vec_t hv;

        vecs[0]  = '{3'd0, 3'd4, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1]  = '{3'd0, 3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{3'd2, 3'd2, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0};
        vecs[3]  = '{3'd2, 3'd2, 32'h00000000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b1};
        vecs[4]  = '{3'd3, 3'd3, 32'hFFFFFFFF, 32'h12345678, 1'b0, 32'h00345678, 1'b0};
        vecs[5]  = '{3'd4, 3'd0, 32'h12000000, 32'h00000034, 1'b0, 32'h12000034, 1'b0};
        vecs[6]  = '{3'd1, 3'd4, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[7]  = '{3'd5, 3'd7, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 32'h0F0F0F0F, 1'b0};
        vecs[8]  = '{3'd6, 3'd1, 32'h123456AA, 32'h00000000, 1'b0, 32'h00000055, 1'b0};
        vecs[9]  = '{3'd7, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};
        vecs[10] = '{3'd0, 3'd1, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[11] = '{3'd2, 3'd1, 32'h00000005, 32'h00000002, 1'b1, 32'h00000002, 1'b0};
        vecs[12] = '{3'd0, 3'd4, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_ci    = 1'b0;
        bus.res_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_co", bus.res_co, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_ci", bus.alu_ci, 0);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure in DONE with a competing command that must be ignored.
        hv = '{3'd0, 3'd2, 32'h000001FF, 32'h00000001, 1'b0, 32'h00000200, 1'b0};
        drive_cmd(hv);
        @(posedge clk);
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            bus.cmd_valid = 1'b0;
            seen = bus.res_valid;
        end
        check("hold_valid_timeout", seen, 1);
        for (int k = 0; k < 3; k++) begin
            bus.cmd_op    = 3'd4;
            bus.cmd_a     = 32'hDEADBEEF;
            bus.cmd_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_res_valid", bus.res_valid, 1);
            check("hold_res_data", bus.res_data, 32'h00000200);
            check("hold_res_co", bus.res_co, 0);
            check("hold_cmd_ready", bus.cmd_ready, 0);
        end
        $display("txn hold op=0 len=2 res=%h co=%b", bus.res_data, bus.res_co);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("hold_post_cmd_ready", bus.cmd_ready, 1);
        check("hold_post_res_valid", bus.res_valid, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.res_valid;
        end
        check("hold_no_spurious_result", seen, 0);

        // Reset asserted in the second RUN cycle aborts the command.
        hv = '{3'd0, 3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        drive_cmd(hv);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_cmd_ready", bus.cmd_ready, 1);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_res_data", bus.res_data, 0);
        check("abort_res_co", bus.res_co, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | bus.res_valid;
        end
        check("abort_no_result", seen, 0);
        $display("txn abort op=0 len=4 res_valid_seen=%b", seen);

        // Controller must still work normally after the abort.
        run_vec(99, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
